condlogic: RTL

Conditional-execution unit for the multi-cycle ARM datapath; the consumer of the ALU's `{N,Z,C,V}` flag vector.
- Holds the architectural flag register and evaluates the instruction's 4-bit condition field against it.
- Latches the pass/fail result once per instruction in the decode cycle.
- Gates the main FSM's PC, register-file and memory write strobes for the rest of that instruction.

---
 rtl/condlogic.sv | 130 +++++++++++++
 1 files changed

// File: rtl/condlogic.sv
// condlogic: conditional-execution unit for the multi-cycle ARM datapath.
// Holds the {N,Z,C,V} flag register, evaluates the instruction's condition
// field against it, latches the pass/fail result in the decode cycle and gates
// the FSM's PC, register-file and memory write strobes with it.
// Optional feature: define COND_STATS_EN to add saturating executed/squashed
// instruction counters (ExecCount/SquashCount); otherwise they read as zero.
module condlogic #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               CondLatch,
    input  logic               PCS,
    input  logic               NextPC,
    input  logic               RegW,
    input  logic               MemW,
    output logic               PCWrite,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               CondEx,
    output logic [3:0]         Flags,
    output logic [COUNT_W-1:0] ExecCount,
    output logic [COUNT_W-1:0] SquashCount
);

    logic       check;
    logic       ok;
    logic       condex_reg;
    logic [3:0] flags_w;
    logic       n_flag, z_flag, c_flag, v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_w;

    // Condition decode against the pre-update flag register.
    always_comb begin
        check = 1'b0;
        unique case (Cond)
            4'b0000: check = z_flag;
            4'b0001: check = ~z_flag;
            4'b0010: check = c_flag;
            4'b0011: check = ~c_flag;
            4'b0100: check = n_flag;
            4'b0101: check = ~n_flag;
            4'b0110: check = v_flag;
            4'b0111: check = ~v_flag;
            4'b1000: check = c_flag & ~z_flag;
            4'b1001: check = ~c_flag | z_flag;
            4'b1010: check = (n_flag == v_flag);
            4'b1011: check = (n_flag != v_flag);
            4'b1100: check = ~z_flag & (n_flag == v_flag);
            4'b1101: check = z_flag | (n_flag != v_flag);
            default: check = 1'b1;
        endcase
    end

    // In the decode cycle the fresh result gates writes; afterwards the
    // latched one does. Holding reset squashes any write still pending.
    assign ok = reset & (CondLatch ? check : condex_reg);

    // Latch the condition result once per instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            condex_reg <= 1'b0;
        end else if (CondLatch) begin
            condex_reg <= check;
        end
    end

    // Flag register as two independently written halves:
    // half 0 = {C,V} (FlagW[0]), half 1 = {N,Z} (FlagW[1]).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_flag_half
            logic [1:0] half_reg;

            // Update this half only when its write enable and the gate agree.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    half_reg <= 2'b00;
                end else if (FlagW[gi] && ok) begin
                    half_reg <= ALUFlags[2*gi +: 2];
                end
            end

            assign flags_w[2*gi +: 2] = half_reg;
        end
    endgenerate

    // Gated write strobes; the fetch-state PC increment bypasses the gate.
    always_comb begin
        PCWrite  = (PCS & ok) | NextPC;
        RegWrite = RegW & ok;
        MemWrite = MemW & ok;
    end

    assign CondEx = condex_reg;
    assign Flags  = flags_w;

`ifdef COND_STATS_EN
    logic [COUNT_W-1:0] exec_count_reg;
    logic [COUNT_W-1:0] squash_count_reg;

    // Count each latched instruction as executed or squashed, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_count_reg   <= '0;
            squash_count_reg <= '0;
        end else if (CondLatch) begin
            if (check) begin
                if (exec_count_reg != {COUNT_W{1'b1}}) begin
                    exec_count_reg <= exec_count_reg + 1'b1;
                end
            end else begin
                if (squash_count_reg != {COUNT_W{1'b1}}) begin
                    squash_count_reg <= squash_count_reg + 1'b1;
                end
            end
        end
    end

    assign ExecCount   = exec_count_reg;
    assign SquashCount = squash_count_reg;
`else
    assign ExecCount   = '0;
    assign SquashCount = '0;
`endif

endmodule
